cpu_mem_loader: RTL and testbench

- Host-side controller that drives the CPU's external memory ports (`addr_ext*`, `wen_ext*`, `ren_ext*`, `wdata_ext*`, `rdata_ext*`) from the other end.
- Loads a program into instruction memory and initial data into data memory from a valid/ready input word stream.
- Then drives the CPU `enable` for a programmed number of cycles.
- Finally reads back a data-memory window onto a valid/ready output stream.
- Sits between the testbench/host link and the `cpu` top.

---
 rtl/cpu_mem_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_mem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - host-side loader: stream program/data into cpu memories, run, dump data window
module cpu_mem_loader #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11,
  parameter int RUN_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  imem_len,
  input  logic [LEN_W-1:0]  dmem_len,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic [LEN_W-1:0]  dump_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              cpu_enable,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W:0]      k_q, k_d, k_inc;
  logic [RUN_W:0]      run_cnt_q, run_cnt_d;
  logic [LEN_W-1:0]    imem_len_q, imem_len_d, dmem_len_q, dmem_len_d, dump_len_q, dump_len_d;
  logic [RUN_W-1:0]    run_len_q, run_len_d;
  logic                wen_q, wen_d, wen2_q, wen2_d, ren2_q, ren2_d;
  logic                cpu_en_q, cpu_en_d, m_valid_q, m_valid_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]         addr_q, addr_d, addr2_q, addr2_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, wdata2_q, wdata2_d, m_data_q, m_data_d;
  logic                take_start, hs_in;
  logic [LEN_W-1:0]    dmem_cfg, dump_cfg;
  logic [RUN_W-1:0]    run_cfg;
  state_t              after_i, after_d, after_r;
  logic                unused_rdata;

  assign unused_rdata = ^rdata_ext;
  assign s_ready      = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
  assign hs_in        = s_valid & s_ready;
  assign k_inc        = k_q + 1'b1;
  assign take_start   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // On start the fresh inputs pick the first phase; afterwards the latched copies do.
  assign dmem_cfg = take_start ? dmem_len   : dmem_len_q;
  assign run_cfg  = take_start ? run_cycles : run_len_q;
  assign dump_cfg = take_start ? dump_len   : dump_len_q;
  assign after_r  = (dump_cfg != '0) ? S_DUMP_RD : S_DONE;
  assign after_d  = (run_cfg  != '0) ? S_RUN     : after_r;
  assign after_i  = (dmem_cfg != '0) ? S_LOAD_D  : after_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    run_cnt_d  = run_cnt_q;
    imem_len_d = imem_len_q;
    dmem_len_d = dmem_len_q;
    run_len_d  = run_len_q;
    dump_len_d = dump_len_q;
    wen_d      = 1'b0;
    wen2_d     = 1'b0;
    ren2_d     = 1'b0;
    cpu_en_d   = 1'b0;
    addr_d     = addr_q;
    addr2_d    = addr2_q;
    wdata_d    = wdata_q;
    wdata2_d   = wdata2_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (take_start) begin
          imem_len_d = imem_len;
          dmem_len_d = dmem_len;
          run_len_d  = run_cycles;
          dump_len_d = dump_len;
          k_d        = '0;
          run_cnt_d  = '0;
          state_d    = (imem_len != '0) ? S_LOAD_I : after_i;
        end
      end
      S_LOAD_I: begin
        if (hs_in) begin
          wen_d   = 1'b1;
          addr_d  = {{(32-LEN_W-3){1'b0}}, k_q, 2'b00};
          wdata_d = s_data;
          if (k_inc == {1'b0, imem_len_q}) begin
            k_d     = '0;
            state_d = after_i;
          end else begin
            k_d = k_inc;
          end
        end
      end
      S_LOAD_D: begin
        if (hs_in) begin
          wen2_d   = 1'b1;
          addr2_d  = {{(32-LEN_W-3){1'b0}}, k_q, 2'b00};
          wdata2_d = s_data;
          if (k_inc == {1'b0, dmem_len_q}) begin
            k_d     = '0;
            state_d = after_d;
          end else begin
            k_d = k_inc;
          end
        end
      end
      S_RUN: begin
        // cpu_enable is registered, so it trails RUN entry by one cycle and clears the last write
        if (run_cnt_q < {1'b0, run_len_q}) begin
          cpu_en_d  = 1'b1;
          run_cnt_d = run_cnt_q + 1'b1;
        end else begin
          run_cnt_d = '0;
          state_d   = after_r;
        end
      end
      S_DUMP_RD: begin
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = rdata_ext_2;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          if (k_inc < {1'b0, dump_len_q}) begin
            k_d     = k_inc;
            state_d = S_DUMP_RD;
          end else begin
            k_d     = '0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DUMP_RD) begin
      ren2_d  = 1'b1;
      addr2_d = {{(32-LEN_W-3){1'b0}}, k_d, 2'b00};
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      run_cnt_q  <= '0;
      imem_len_q <= '0;
      dmem_len_q <= '0;
      run_len_q  <= '0;
      dump_len_q <= '0;
      wen_q      <= 1'b0;
      wen2_q     <= 1'b0;
      ren2_q     <= 1'b0;
      cpu_en_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      addr2_q    <= '0;
      wdata_q    <= '0;
      wdata2_q   <= '0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      run_cnt_q  <= run_cnt_d;
      imem_len_q <= imem_len_d;
      dmem_len_q <= dmem_len_d;
      run_len_q  <= run_len_d;
      dump_len_q <= dump_len_d;
      wen_q      <= wen_d;
      wen2_q     <= wen2_d;
      ren2_q     <= ren2_d;
      cpu_en_q   <= cpu_en_d;
      m_valid_q  <= m_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      addr2_q    <= addr2_d;
      wdata_q    <= wdata_d;
      wdata2_q   <= wdata2_d;
      m_data_q   <= m_data_d;
    end
  end

  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext_2   = wen2_q;
  assign ren_ext_2   = ren2_q;
  assign addr_ext_2  = addr2_q;
  assign wdata_ext_2 = wdata2_q;
  assign cpu_enable  = cpu_en_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb/tb_cpu_mem_loader.sv - directed self-checking bench for cpu_mem_loader
module tb_cpu_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic [10:0] imem_len, dmem_len, dump_len;
  logic [15:0] run_cycles;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] rdata_ext;
  logic [31:0] rdata_ext_2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, done_cyc, en_first, en_last;
  int n_iw, n_dw, n_out, n_ren, n_en, n_overlap, pulse_err, hold_err;
  int word_idx, out_idx, stall_word, stall_left, n_stall;
  logic [31:0] iw_a[16], iw_d[16], dw_a[16], dw_d[16], outd[16];

  cpu_mem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory model: synchronous read returning address + 0x100
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= addr_ext_2 + 32'h100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (wen_ext) begin
      if (n_iw < 16) begin iw_a[n_iw] = addr_ext; iw_d[n_iw] = wdata_ext; end
      n_iw++;
    end
    if (wen_ext_2) begin
      if (n_dw < 16) begin dw_a[n_dw] = addr_ext_2; dw_d[n_dw] = wdata_ext_2; end
      n_dw++;
    end
    if (ren_ext_2) n_ren++;
    if (cpu_enable) begin
      n_en++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if ((wen_ext | wen_ext_2) && (ren_ext_2 | ren_ext | cpu_enable)) n_overlap++;
    if (done && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic do_start(input int il, input int dl, input int rl, input int ul);
    cyc = 0; done_cyc = -1; en_first = -1; en_last = -1;
    n_iw = 0; n_dw = 0; n_out = 0; n_ren = 0; n_en = 0; n_overlap = 0;
    pulse_err = 0; hold_err = 0; word_idx = 0; out_idx = 0; n_stall = 0;
    imem_len = 11'(il); dmem_len = 11'(dl); run_cycles = 16'(rl); dump_len = 11'(ul);
    s_valid = 1'b0; m_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int n, input bit toggle, input bit late_start);
    bit hs_in, hs_out;
    for (int c = 0; c < n; c++) begin
      s_valid = toggle ? (c % 2 == 0) : 1'b1;
      s_data  = 32'hA0 + 32'(word_idx);
      start   = late_start && (c == 0);
      if (start) begin imem_len = 11'd7; dmem_len = 11'd7; end
      m_ready = !(m_valid && out_idx == stall_word && stall_left > 0);
      if (!m_ready) begin
        stall_left--;
        n_stall++;
        if (m_data !== 32'h104) hold_err++;
      end
      hs_in  = s_valid && s_ready;
      hs_out = m_valid && m_ready;
      if (hs_out) begin
        if (n_out < 16) outd[n_out] = m_data;
        n_out++;
      end
      tick();
      if ((wen_ext | wen_ext_2) !== hs_in) pulse_err++;
      if (hs_in) word_idx++;
      if (hs_out) out_idx++;
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    imem_len = '0; dmem_len = '0; run_cycles = '0; dump_len = '0;
    rdata_ext = '0; stall_word = -1; stall_left = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {23'd0, busy, done, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2, m_valid, s_ready}, 32'd0);
    check("rst_addr", addr_ext | addr_ext_2, 32'd0);
    check("rst_data", wdata_ext | wdata_ext_2 | m_data, 32'd0);
    arst_n = 1'b1;

    // Load 3 instruction words + 2 data words, valid held high
    do_start(3, 2, 0, 0);
    check("t1_busy_sready", {30'd0, busy, s_ready}, 32'd3);
    run(10, 1'b0, 1'b0);
    check("t1_n_iw", n_iw, 3);
    check("t1_iw0", {iw_a[0][7:0], iw_d[0][23:0]}, {8'h00, 24'hA0});
    check("t1_iw1", {iw_a[1][7:0], iw_d[1][23:0]}, {8'h04, 24'hA1});
    check("t1_iw2", {iw_a[2][7:0], iw_d[2][23:0]}, {8'h08, 24'hA2});
    check("t1_n_dw", n_dw, 2);
    check("t1_dw0", {dw_a[0][7:0], dw_d[0][23:0]}, {8'h00, 24'hA3});
    check("t1_dw1", {dw_a[1][7:0], dw_d[1][23:0]}, {8'h04, 24'hA4});
    check("t1_done_cyc", done_cyc, 6);
    check("t1_pulse_err", pulse_err, 0);
    check("t1_no_en_ren", n_en + n_ren, 0);

    // Same load, valid toggling
    do_start(3, 2, 0, 0);
    run(16, 1'b1, 1'b0);
    check("t2_n_iw", n_iw, 3);
    check("t2_iw2", {iw_a[2][7:0], iw_d[2][23:0]}, {8'h08, 24'hA2});
    check("t2_n_dw", n_dw, 2);
    check("t2_dw1", {dw_a[1][7:0], dw_d[1][23:0]}, {8'h04, 24'hA4});
    check("t2_pulse_err", pulse_err, 0);
    check("t2_done", done, 1);

    // Run only, 5 cycles
    do_start(0, 0, 5, 0);
    run(10, 1'b0, 1'b0);
    check("t3_n_en", n_en, 5);
    check("t3_en_span", {en_first[15:0], en_last[15:0]}, {16'd2, 16'd6});
    check("t3_done_cyc", done_cyc, 7);
    check("t3_no_writes", n_iw + n_dw + n_ren, 0);

    // Dump 3 words, word 1 stalled 4 cycles
    stall_word = 1; stall_left = 4;
    do_start(0, 0, 0, 3);
    run(25, 1'b0, 1'b0);
    stall_word = -1;
    check("t4_n_out", n_out, 3);
    check("t4_out0", outd[0], 32'h100);
    check("t4_out1", outd[1], 32'h104);
    check("t4_out2", outd[2], 32'h108);
    check("t4_stalls", n_stall, 4);
    check("t4_hold_err", hold_err, 0);
    check("t4_n_ren", n_ren, 3);
    check("t4_done_cyc", done_cyc, 14);
    check("t4_no_writes", n_iw + n_dw, 0);

    // Reset in the middle of a 100-cycle run
    do_start(0, 0, 100, 0);
    repeat (19) tick();
    check("t5_en_before", cpu_enable, 1);
    arst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {24'd0, busy, done, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2, s_ready}, 32'd0);
    #2 arst_n = 1'b1;
    do_start(2, 1, 3, 2);
    run(30, 1'b0, 1'b0);
    check("t5_n_iw", n_iw, 2);
    check("t5_iw1", {iw_a[1][7:0], iw_d[1][23:0]}, {8'h04, 24'hA1});
    check("t5_n_dw", n_dw, 1);
    check("t5_dw0", {dw_a[0][7:0], dw_d[0][23:0]}, {8'h00, 24'hA2});
    check("t5_n_en", n_en, 3);
    check("t5_n_out", n_out, 2);
    check("t5_out1", outd[1], 32'h104);
    check("t5_overlap", n_overlap, 0);
    check("t5_done", done, 1);

    // All lengths zero
    do_start(0, 0, 0, 0);
    check("t6_done_next", {30'd0, done, busy}, 32'd2);
    run(4, 1'b0, 1'b0);
    check("t6_no_enables", n_iw + n_dw + n_ren + n_en, 0);

    // start pulsed during LOAD_I with other config is ignored
    do_start(2, 0, 0, 0);
    run(8, 1'b1, 1'b1);
    check("t7_n_iw", n_iw, 2);
    check("t7_iw1", {iw_a[1][7:0], iw_d[1][23:0]}, {8'h04, 24'hA1});
    check("t7_n_dw", n_dw, 0);
    check("t7_done_cyc", done_cyc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
